ssd_digit_scanner: RTL and testbench
====================================

Name: ssd_digit_scanner

Overview:
- Time-multiplexed scan controller for a bank of common-anode seven-segment digits.
- Accepts a multi-nibble display value through a valid/ready handshake and presents one nibble at a time on hex_o, which feeds the hex-to-segment decoder directly downstream.
- Drives the active-low digit enables, with inter-digit ghost blanking, optional leading-zero suppression and tear-free frame-boundary updates.

Parameters:
- digits_p, 4: number of digits scanned; legal range 1..8.
- prescale_p, 1000: clk_i cycles per digit slot; must be >= 2.
- blank_cycles_p, 1: cycles at the start of each slot with all digits off; must be < prescale_p.

Ports:
- clk_i  in  1  system clock.
- reset_ni  in  1  reset, asynchronous assert, active-low.
- valid_i  in  1  producer has a new display value.
- ready_o  out  1  scanner can accept a value.
- data_i  in  4*digits_p  nibble k = data_i[4k+3:4k]; digit 0 is least significant.
- dp_i  in  digits_p  decimal point per digit, 1 = lit; captured with data_i.
- lz_suppress_i  in  1  leading-zero suppression enable; sampled live.
- hex_o  out  4  nibble for the current digit; goes to the decoder hex input.
- digit_en_o  out  digits_p  active-low digit enables; at most one bit is 0.
- dp_o  out  1  active-low decimal point for the current digit.
- blank_o  out  1  1 = current slot is dark.

Behaviour:
- Clock and reset: one clock domain, clk_i. reset_ni is asynchronous and active-low.
- Reset values:
  - prescale count 0, digit index 0.
  - display register 0, display dp 0, pending register 0, pending_v 0.
  - Outputs during and after reset: ready_o=1, hex_o=0, digit_en_o all 1s, dp_o=1, blank_o=1.
- Prescaler:
  - cnt counts 0..prescale_p-1 and wraps to 0; width $clog2(prescale_p).
  - tick = (cnt == prescale_p-1).
- Digit index:
  - On tick, idx <= (idx == digits_p-1) ? 0 : idx+1.
  - frame_wrap = tick && idx == digits_p-1.
- Handshake:
  - ready_o = ~pending_v.
  - On valid_i && ready_o: pending <= {data_i, dp_i} and pending_v <= 1.
  - While ready_o = 0, the producer holds valid_i and data_i stable. No capture occurs.
- Frame update:
  - On frame_wrap with pending_v = 1: display <= pending and pending_v <= 0.
  - A new value therefore first appears at the digit 0 slot.
  - No mid-frame tearing.
- Simultaneous events:
  - Accept and frame_wrap in the same cycle while pending is empty: the value goes into pending only. No bypass; it displays one frame later.
  - Accept and transfer in the same cycle cannot occur, because ready_o = 0 whenever pending_v = 1.
- Outputs, combinational from registered state:
  - hex_o = display nibble[idx].
  - gap = cnt < blank_cycles_p.
  - lz = lz_suppress_i && idx != 0 && all display nibbles idx..digits_p-1 are zero. Digit 0 is never suppressed.
  - blank_o = gap || lz.
  - digit_en_o = blank_o ? all 1s : ~(1 << idx).
  - dp_o = blank_o ? 1 : ~display_dp[idx].
- Reset mid-operation: all state returns to reset values immediately. Any pending value is discarded.
- Latency:
  - Accepted value to first visible digit 0: between 1 and (digits_p*prescale_p + 1) cycles after the next frame_wrap, bounded by 2*digits_p*prescale_p.
- digits_p = 1: idx is constant 0, and frame_wrap = tick.

Decomposition:
- Package ssd_pkg:
  - max_digits_c = 8.
  - seg_off_c = 7'h7F (active-low all-off).
  - en_off_c helper.
  - struct disp_t {nibbles, dp}.
- Sub-module ssd_tick_gen, parameter prescale_p:
  - Ports clk_i, reset_ni, cnt_o, tick_o.
  - Reused by other scan and timebase blocks.
- The decoder is instantiated by the parent alongside this block, not inside it.

Test Plan (digits_p=4, prescale_p=4, blank_cycles_p=1 unless noted):
- Reset scan:
  - Stimulus: hold reset_ni=0 for 3 cycles, then release with no input.
  - Required: digit_en_o=4'b1111 and ready_o=1 during reset. After release, digit_en_o = 1111, 1110, 1110, 1110, then 1111, 1101, ... per 4-cycle slot, hex_o=0, and dp_o=1 in every cycle.
- Accept and frame update:
  - Stimulus: valid_i with data_i=16'h1A3F, dp_i=4'b0100 mid-frame.
  - Required: ready_o=0 the next cycle. Old value is shown until frame_wrap. Then hex_o = F, 3, A, 1 in slots 0..3, dp_o=0 only in slot 2, and ready_o returns to 1.
- Backpressure:
  - Stimulus: second valid_i with 16'h2222 while pending_v=1.
  - Required: no capture until ready_o=1. Held data is then accepted and displayed one frame after 16'h1A3F.
- Leading-zero suppression:
  - Stimulus: data_i=16'h0005 with lz_suppress_i=1.
  - Required: slots 1–3 have blank_o=1 and digit_en_o=1111. Slot 0 shows 5.
  - Stimulus: data_i=16'h0000.
  - Required: slot 0 shows 0.
- Simultaneous accept on frame_wrap:
  - Stimulus: valid_i asserted exactly on the frame_wrap cycle.
  - Required: the value is not shown in the immediately following frame, and is shown in the one after.
- Async reset mid-frame:
  - Stimulus: drop reset_ni mid-cycle at idx=2 with pending_v=1.
  - Required: outputs go to reset values without waiting for a clock edge. Pending is lost, and 0000 is displayed after release.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan blocks.
package ssd_pkg;

  localparam int unsigned max_digits_c = 8;

  // Active-low: all segments off / all digit enables off.
  localparam logic [6:0]              seg_off_c = 7'h7F;
  localparam logic [max_digits_c-1:0] en_off_c  = '1;

  typedef struct packed {
    logic [4*max_digits_c-1:0] nibbles;
    logic [max_digits_c-1:0]   dp;
  } disp_t;

endpackage

// File: rtl/ssd_tick_gen.sv
// Free-running prescaler: counts 0..prescale_p-1 and flags the last count.
module ssd_tick_gen #(
  parameter int unsigned prescale_p = 1000,
  localparam int unsigned cnt_w_c = $clog2(prescale_p)
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  output logic [cnt_w_c-1:0] cnt_o,
  output logic               tick_o
);

  logic [cnt_w_c-1:0] cnt_q;

  assign cnt_o  = cnt_q;
  assign tick_o = (cnt_q == cnt_w_c'(prescale_p - 1));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ssd_digit_scanner.sv
// Time-multiplexed common-anode digit scanner with ghost blanking, leading-zero
// suppression and frame-boundary display updates.
module ssd_digit_scanner
  import ssd_pkg::*;
#(
  parameter int unsigned digits_p       = 4,
  parameter int unsigned prescale_p     = 1000,
  parameter int unsigned blank_cycles_p = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [4*digits_p-1:0] data_i,
  input  logic [digits_p-1:0]   dp_i,
  input  logic                  lz_suppress_i,
  output logic [3:0]            hex_o,
  output logic [digits_p-1:0]   digit_en_o,
  output logic                  dp_o,
  output logic                  blank_o
);

  localparam int unsigned cnt_w_c = $clog2(prescale_p);
  localparam int unsigned idx_w_c = (digits_p > 1) ? $clog2(digits_p) : 1;

  logic [cnt_w_c-1:0] cnt;
  logic               tick;
  logic [idx_w_c-1:0] idx_q;
  logic               last_idx;
  logic               frame_wrap;
  disp_t              pending_q;
  logic               pending_v_q;
  disp_t              display_q;
  logic               gap;
  logic               lz;
  logic               nz_above;

  ssd_tick_gen #(
    .prescale_p(prescale_p)
  ) u_tick_gen (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .cnt_o   (cnt),
    .tick_o  (tick)
  );

  assign last_idx   = (idx_q == idx_w_c'(digits_p - 1));
  assign frame_wrap = tick && last_idx;
  assign ready_o    = ~pending_v_q;

  // The transfer and capture branches are exclusive since ready_o is low
  // whenever pending holds a value; an accept on frame_wrap is not bypassed.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      idx_q       <= '0;
      pending_q   <= '0;
      pending_v_q <= 1'b0;
      display_q   <= '0;
    end else begin
      if (tick) begin
        idx_q <= last_idx ? '0 : idx_q + 1'b1;
      end
      if (frame_wrap && pending_v_q) begin
        display_q   <= pending_q;
        pending_v_q <= 1'b0;
      end else if (valid_i && ready_o) begin
        pending_q.nibbles <= (4 * max_digits_c)'(data_i);
        pending_q.dp      <= max_digits_c'(dp_i);
        pending_v_q       <= 1'b1;
      end
    end
  end

  always_comb begin
    nz_above = 1'b0;
    for (int k = 0; k < int'(digits_p); k++) begin
      if (k >= int'(idx_q) && display_q.nibbles[4*k +: 4] != 4'h0) begin
        nz_above = 1'b1;
      end
    end
  end

  assign gap        = (cnt < cnt_w_c'(blank_cycles_p));
  assign lz         = lz_suppress_i && (idx_q != '0) && !nz_above;
  assign blank_o    = gap || lz;
  assign hex_o      = display_q.nibbles[4*int'(idx_q) +: 4];
  assign digit_en_o = blank_o ? en_off_c[digits_p-1:0] : ~(digits_p'(1) << idx_q);
  assign dp_o       = blank_o ? 1'b1 : ~display_q.dp[idx_q];

endmodule

// File: tb/tb_ssd_digit_scanner.sv
// Directed bench for ssd_digit_scanner with 4 digits, 4-cycle slots, 1 blank cycle.
module tb_ssd_digit_scanner;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  hex;
  logic [3:0]  digit_en;
  logic        dp_out;
  logic        blank;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  ssd_digit_scanner #(
    .digits_p      (4),
    .prescale_p    (4),
    .blank_cycles_p(1)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .valid_i      (valid),
    .ready_o      (ready),
    .data_i       (data),
    .dp_i         (dp_in),
    .lz_suppress_i(lz_suppress),
    .hex_o        (hex),
    .digit_en_o   (digit_en),
    .dp_o         (dp_out),
    .blank_o      (blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Packs {hex, digit_en, dp, blank} into one comparison.
  task automatic chk_out(input string tag, input logic [3:0] e_hex, input logic [3:0] e_en,
                         input logic e_dp, input logic e_blank);
    chk(tag, {6'b0, hex, digit_en, dp_out, blank}, {6'b0, e_hex, e_en, e_dp, e_blank});
  endtask

  task automatic go(input int target);
    if (target < cyc) begin
      $display("FAIL go: cycle %0d already past target %0d", cyc, target);
      $fatal(1);
    end
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  logic [3:0] scan_exp [8] = '{4'b1111, 4'b1110, 4'b1110, 4'b1110,
                               4'b1111, 4'b1101, 4'b1101, 4'b1101};

  initial begin
    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    chk_out("rst_out", 4'h0, 4'b1111, 1'b1, 1'b1);
    chk("rst_ready", 16'(ready), 16'd1);
    reset_ni = 1'b1;
    cyc = 0;

    // Idle scan: cycle cyc has cnt = cyc%4, idx = (cyc/4)%4.
    for (int i = 0; i < 8; i++) begin
      go(i);
      chk_out("scan", 4'h0, scan_exp[i], 1'b1, scan_exp[i] == 4'b1111);
    end

    // Accept 1A3F mid-frame.
    go(10);
    chk("acc_ready_pre", 16'(ready), 16'd1);
    valid = 1'b1; data = 16'h1A3F; dp_in = 4'b0100;
    go(11);
    chk("acc_ready_low", 16'(ready), 16'd0);
    data = 16'h2222; dp_in = 4'b0000;   // backpressured second value held
    go(13);
    chk_out("old_value", 4'h0, 4'b0111, 1'b1, 1'b0);
    go(14);
    chk("bp_ready_low", 16'(ready), 16'd0);

    // Frame 1 shows 1A3F; the held 2222 is taken now.
    go(16);
    chk("f1_ready", 16'(ready), 16'd1);
    chk_out("f1_gap", 4'hF, 4'b1111, 1'b1, 1'b1);
    go(17);
    chk("bp_taken", 16'(ready), 16'd0);
    valid = 1'b0;
    chk_out("f1_d0", 4'hF, 4'b1110, 1'b1, 1'b0);
    go(21);
    chk_out("f1_d1", 4'h3, 4'b1101, 1'b1, 1'b0);
    go(24);
    chk_out("f1_d2_gap", 4'hA, 4'b1111, 1'b1, 1'b1);
    go(25);
    chk_out("f1_d2", 4'hA, 4'b1011, 1'b0, 1'b0);
    go(29);
    chk_out("f1_d3", 4'h1, 4'b0111, 1'b1, 1'b0);

    // Frame 2 shows 2222; accept 0005 with suppression on.
    go(32);
    chk("f2_ready", 16'(ready), 16'd1);
    go(33);
    chk_out("f2_d0", 4'h2, 4'b1110, 1'b1, 1'b0);
    valid = 1'b1; data = 16'h0005; lz_suppress = 1'b1;
    go(34);
    valid = 1'b0;
    chk("lz_acc", 16'(ready), 16'd0);
    go(45);
    chk_out("f2_d3", 4'h2, 4'b0111, 1'b1, 1'b0);

    // Frame 3 shows 0005 with leading zeros dark; accept 0000.
    go(49);
    chk_out("lz_d0", 4'h5, 4'b1110, 1'b1, 1'b0);
    valid = 1'b1; data = 16'h0000;
    go(50);
    valid = 1'b0;
    go(53);
    chk_out("lz_d1", 4'h0, 4'b1111, 1'b1, 1'b1);
    go(57);
    chk_out("lz_d2", 4'h0, 4'b1111, 1'b1, 1'b1);
    go(61);
    chk_out("lz_d3", 4'h0, 4'b1111, 1'b1, 1'b1);

    // Frame 4 shows 0000: digit 0 stays lit.
    go(65);
    chk_out("zero_d0", 4'h0, 4'b1110, 1'b1, 1'b0);
    go(69);
    chk_out("zero_d1", 4'h0, 4'b1111, 1'b1, 1'b1);
    go(70);
    lz_suppress = 1'b0;
    go(73);
    chk_out("lz_live_off", 4'h0, 4'b1011, 1'b1, 1'b0);

    // Accept on the frame_wrap cycle: lands in pending only.
    go(79);
    chk("wrap_ready", 16'(ready), 16'd1);
    valid = 1'b1; data = 16'h7777;
    go(80);
    valid = 1'b0;
    chk("wrap_pending", 16'(ready), 16'd0);
    go(81);
    chk_out("wrap_no_bypass", 4'h0, 4'b1110, 1'b1, 1'b0);
    go(96);
    chk("f6_ready", 16'(ready), 16'd1);
    go(97);
    chk_out("wrap_shown", 4'h7, 4'b1110, 1'b1, 1'b0);

    // Async reset at idx 2 with 9999 pending.
    go(98);
    valid = 1'b1; data = 16'h9999;
    go(99);
    valid = 1'b0;
    chk("pre_rst_pending", 16'(ready), 16'd0);
    go(105);
    chk_out("pre_rst", 4'h7, 4'b1011, 1'b1, 1'b0);
    #2;
    reset_ni = 1'b0;
    #1;
    chk_out("async_rst_out", 4'h0, 4'b1111, 1'b1, 1'b1);
    chk("async_rst_ready", 16'(ready), 16'd1);
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
    cyc = 0;
    chk_out("post_rst_gap", 4'h0, 4'b1111, 1'b1, 1'b1);
    go(1);
    chk_out("post_rst_d0", 4'h0, 4'b1110, 1'b1, 1'b0);
    go(17);
    chk_out("pending_lost", 4'h0, 4'b1110, 1'b1, 1'b0);
    chk("post_rst_ready", 16'(ready), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
